// File: rtl/remap_cache_fill_ctrl_pkg.sv
// Shared types and default geometry for the remap-cache fill path.
// Fill FSM state encoding plus derived widths for the default bank configuration.
package remap_cache_fill_ctrl_pkg;

    localparam int RC_BW           = 8;
    localparam int RC_NDATA        = 32;
    localparam int RC_NBANK        = 16;
    localparam int RC_XOR_BW       = 4;
    localparam int RC_CLOG2_NDATA  = $clog2(RC_NDATA);
    localparam int RC_CLOG2_NBANK  = $clog2(RC_NBANK);
    localparam int RC_CLOG2_XOR_BW = $clog2(RC_XOR_BW);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/remap_cache_fill_ctrl_bfly.sv
// XOR-scheduled butterfly permuting one row across the banks; purely combinational.
// Stage k swaps bank pairs differing in bit k when enabled and the selected address bit is set.
module BankSramButterflyWriteIf #(
    parameter int BW           = 8,
    parameter int NBANK        = 16,
    parameter int XOR_BW       = 4,
    parameter int CLOG2_NBANK  = $clog2(NBANK),
    parameter int CLOG2_XOR_BW = $clog2(XOR_BW)
) (
    input  logic [BW*NBANK-1:0]                  i_data,
    input  logic [XOR_BW-1:0]                    i_addr_slice,
    input  logic [CLOG2_NBANK-1:0]               i_xor_mask,
    input  logic [CLOG2_NBANK*CLOG2_XOR_BW-1:0]  i_xor_scheme,
    output logic [BW*NBANK-1:0]                  o_data
);

    logic [BW*NBANK-1:0] w_cur;
    logic [BW*NBANK-1:0] w_nxt;

    always_comb begin
        w_cur = i_data;
        w_nxt = i_data;
        for (int k = 0; k < CLOG2_NBANK; k++) begin
            w_nxt = w_cur;
            if (i_xor_mask[k] && i_addr_slice[i_xor_scheme[k*CLOG2_XOR_BW +: CLOG2_XOR_BW]]) begin
                for (int b = 0; b < NBANK; b++) begin
                    w_nxt[b*BW +: BW] = w_cur[(b ^ (1 << k))*BW +: BW];
                end
            end
            w_cur = w_nxt;
        end
        o_data = w_cur;
    end

endmodule

// File: rtl/remap_cache_fill_ctrl.sv
// Remap-cache bank fill controller: accepts rows, registers once, writes permuted rows to banks.
// Write happens one cycle after accept; i_bank_busy holds the staged row and blocks new accepts.
module remap_cache_fill_ctrl
    import remap_cache_fill_ctrl_pkg::*;
#(
    parameter int BW           = RC_BW,
    parameter int NDATA        = RC_NDATA,
    parameter int NBANK        = RC_NBANK,
    parameter int XOR_BW       = RC_XOR_BW,
    parameter int CLOG2_NDATA  = $clog2(NDATA),
    parameter int CLOG2_NBANK  = $clog2(NBANK),
    parameter int CLOG2_XOR_BW = $clog2(XOR_BW)
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_start,
    input  logic [CLOG2_NDATA-1:0]               i_base,
    input  logic [CLOG2_NDATA:0]                 i_nrow,
    input  logic [CLOG2_NBANK-1:0]               i_xor_mask,
    input  logic [CLOG2_NBANK*CLOG2_XOR_BW-1:0]  i_xor_scheme,
    input  logic                                 i_dval,
    output logic                                 o_drdy,
    input  logic [BW*NBANK-1:0]                  i_data,
    input  logic                                 i_bank_busy,
    output logic [NBANK-1:0]                     o_wen,
    output logic [CLOG2_NDATA-1:0]               o_waddr,
    output logic [BW*NBANK-1:0]                  o_wdata,
    output logic                                 o_busy,
    output logic                                 o_done
);

    localparam logic [CLOG2_NDATA:0] CNT_ONE = (CLOG2_NDATA+1)'(1);

    fill_state_e                          r_state;
    fill_state_e                          w_state_nxt;
    logic [CLOG2_NDATA-1:0]               r_base;
    logic [CLOG2_NDATA:0]                 r_nrow;
    logic [CLOG2_NBANK-1:0]               r_mask;
    logic [CLOG2_NBANK*CLOG2_XOR_BW-1:0]  r_scheme;
    logic [CLOG2_NDATA:0]                 r_acnt;
    logic [CLOG2_NDATA:0]                 r_rcnt;
    logic                                 r_s1_val;
    logic [BW*NBANK-1:0]                  r_s1_data;
    logic [CLOG2_NDATA-1:0]               r_s1_addr;

    logic                                 w_accept;
    logic                                 w_retire;
    logic                                 w_last;
    logic                                 w_start_ok;
    logic [CLOG2_NDATA-1:0]               w_hiaddr;

    assign w_start_ok = (r_state == ST_IDLE) && i_start;
    assign o_drdy     = (r_state == ST_FILL) && (r_acnt < r_nrow) && (!r_s1_val || !i_bank_busy);
    assign w_accept   = o_drdy && i_dval;
    assign w_retire   = r_s1_val && !i_bank_busy;
    assign w_last     = w_retire && (r_rcnt == (r_nrow - CNT_ONE));
    // Truncation to CLOG2_NDATA bits is what wraps the address at NDATA.
    assign w_hiaddr   = r_base + r_acnt[CLOG2_NDATA-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_nxt = (i_nrow == '0) ? ST_DONE : ST_FILL;
            ST_FILL: if (w_last)  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_base    <= '0;
            r_nrow    <= '0;
            r_mask    <= '0;
            r_scheme  <= '0;
            r_acnt    <= '0;
            r_rcnt    <= '0;
            r_s1_val  <= 1'b0;
            r_s1_data <= '0;
            r_s1_addr <= '0;
        end else begin
            if (w_start_ok) begin
                r_base   <= i_base;
                r_nrow   <= i_nrow;
                r_mask   <= i_xor_mask;
                r_scheme <= i_xor_scheme;
                r_acnt   <= '0;
                r_rcnt   <= '0;
            end else begin
                if (w_accept) r_acnt <= r_acnt + CNT_ONE;
                if (w_retire) r_rcnt <= r_rcnt + CNT_ONE;
            end
            if (w_accept) begin
                r_s1_val  <= 1'b1;
                r_s1_data <= i_data;
                r_s1_addr <= w_hiaddr;
            end else if (w_retire) begin
                r_s1_val  <= 1'b0;
            end
        end
    end

    assign o_wen   = {NBANK{w_retire}};
    assign o_waddr = r_s1_addr;
    assign o_busy  = (r_state != ST_IDLE);
    assign o_done  = (r_state == ST_DONE);

    BankSramButterflyWriteIf #(
        .BW           (BW),
        .NBANK        (NBANK),
        .XOR_BW       (XOR_BW),
        .CLOG2_NBANK  (CLOG2_NBANK),
        .CLOG2_XOR_BW (CLOG2_XOR_BW)
    ) u_bfly (
        .i_data       (r_s1_data),
        .i_addr_slice (r_s1_addr[XOR_BW-1:0]),
        .i_xor_mask   (r_mask),
        .i_xor_scheme (r_scheme),
        .o_data       (o_wdata)
    );

endmodule

// File: tb/tb_remap_cache_fill_ctrl.sv
// Bench for remap_cache_fill_ctrl: directed and randomized fills against a row-queue reference model.
module tb_remap_cache_fill_ctrl;

    localparam int BW = 8, NDATA = 32, NBANK = 16, XOR_BW = 4;
    localparam int CN = 5, CB = 4, CX = 2;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic                 i_start;
    logic [CN-1:0]        i_base;
    logic [CN:0]          i_nrow;
    logic [CB-1:0]        i_xor_mask;
    logic [CB*CX-1:0]     i_xor_scheme;
    logic                 i_dval;
    logic                 o_drdy;
    logic [BW*NBANK-1:0]  i_data;
    logic                 i_bank_busy;
    logic [NBANK-1:0]     o_wen;
    logic [CN-1:0]        o_waddr;
    logic [BW*NBANK-1:0]  o_wdata;
    logic                 o_busy;
    logic                 o_done;

    remap_cache_fill_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_base(i_base), .i_nrow(i_nrow),
        .i_xor_mask(i_xor_mask), .i_xor_scheme(i_xor_scheme), .i_dval(i_dval), .o_drdy(o_drdy),
        .i_data(i_data), .i_bank_busy(i_bank_busy), .o_wen(o_wen), .o_waddr(o_waddr),
        .o_wdata(o_wdata), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: 0 idle, 1 filling, 2 done; rows in flight kept as a queue.
    int                  m_mode = 0;
    int                  m_base, m_nrow, m_acc, m_ret;
    logic [CB-1:0]       m_mask;
    logic [CB*CX-1:0]    m_scheme;
    int                  q_addr[$];
    logic [BW*NBANK-1:0] q_data[$];
    int                  wlog[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW*NBANK-1:0] perm(input logic [BW*NBANK-1:0] d, input int addr,
                                                  input logic [CB-1:0] mask, input logic [CB*CX-1:0] sch);
        logic [BW*NBANK-1:0] r;
        int x = 0;
        for (int k = 0; k < CB; k++) begin
            int sel = int'(sch[k*CX +: CX]);
            if (mask[k] && ((addr >> sel) & 1) == 1) x |= (1 << k);
        end
        for (int b = 0; b < NBANK; b++) r[b*BW +: BW] = d[(b ^ x)*BW +: BW];
        return r;
    endfunction

    // Drive one cycle at the falling edge, check outputs, then advance the model across the rising edge.
    task automatic step(input logic st, input logic bb, input logic dv);
        logic [BW*NBANK-1:0] d;
        bit exp_rdy, exp_wen;
        int a;
        d = {$urandom, $urandom, $urandom, $urandom};
        i_start = st; i_bank_busy = bb; i_dval = dv; i_data = d;
        #1;
        exp_rdy = (m_mode == 1) && (m_acc < m_nrow) && (q_addr.size() == 0 || !bb);
        exp_wen = (m_mode == 1) && (q_addr.size() != 0) && !bb;
        chk("drdy", o_drdy, exp_rdy);
        chk("wen", o_wen, {NBANK{exp_wen}});
        chk("busy", o_busy, m_mode != 0);
        chk("done", o_done, m_mode == 2);
        if (exp_wen) begin
            chk("waddr", o_waddr, q_addr[0]);
            chk("wdata", o_wdata, q_data[0]);
            wlog.push_back(int'(o_waddr));
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
            m_ret++;
        end
        if (exp_rdy && dv) begin
            a = (m_base + m_acc) % NDATA;
            q_addr.push_back(a);
            q_data.push_back(perm(d, a, m_mask, m_scheme));
            m_acc++;
        end
        if (m_mode == 2) m_mode = 0;
        else if (m_mode == 0 && st) begin
            m_base = int'(i_base); m_nrow = int'(i_nrow);
            m_mask = i_xor_mask; m_scheme = i_xor_scheme;
            m_acc = 0; m_ret = 0;
            m_mode = (m_nrow == 0) ? 2 : 1;
        end else if (m_mode == 1 && exp_wen && m_ret == m_nrow) m_mode = 2;
        @(negedge i_clk);
    endtask

    task automatic run(input logic [63:0] bpat, input int busy_pct, input int dv_pct);
        for (int c = 0; c < 300; c++) begin
            step(1'b0, bpat[c % 64] | ($urandom_range(0, 99) < busy_pct), $urandom_range(0, 99) < dv_pct);
            if (m_mode == 0) break;
        end
        chk("fill_timeout", m_mode == 0, 1'b1);
        i_dval = 1'b0; i_bank_busy = 1'b0;
    endtask

    task automatic fill(input int base, input int nrow, input int mask, input int sch,
                        input logic [63:0] bpat, input int busy_pct, input int dv_pct);
        i_base = CN'(base); i_nrow = (CN+1)'(nrow);
        i_xor_mask = CB'(mask); i_xor_scheme = (CB*CX)'(sch);
        wlog.delete();
        step(1'b1, 1'b0, 1'b0);
        run(bpat, busy_pct, dv_pct);
        chk("nwrites", wlog.size(), nrow);
    endtask

    task automatic check_reset_outputs();
        chk("rst_drdy", o_drdy, 0);
        chk("rst_wen", o_wen, 0);
        chk("rst_waddr", o_waddr, 0);
        chk("rst_wdata", o_wdata, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
    endtask

    initial begin
        int exp_w[4];
        int exp_m[6];
        i_rst = 1'b0; i_start = 1'b0; i_base = '0; i_nrow = '0; i_xor_mask = '0;
        i_xor_scheme = '0; i_dval = 1'b0; i_data = '0; i_bank_busy = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);

        // Basic fill, back-to-back, no permutation.
        fill(0, 4, 0, 0, 64'h0, 0, 100);
        exp_w = '{0, 1, 2, 3};
        for (int i = 0; i < 4 && i < wlog.size(); i++) chk("basic_addr", wlog[i], exp_w[i]);

        // Address wrap at NDATA.
        fill(30, 4, 0, 0, 64'h0, 0, 100);
        exp_w = '{30, 31, 0, 1};
        for (int i = 0; i < 4 && i < wlog.size(); i++) chk("wrap_addr", wlog[i], exp_w[i]);

        // Stage-0 swap on odd addresses.
        fill(0, 4, 1, 0, 64'h0, 0, 100);

        // Three-cycle bank-busy stall mid-fill.
        fill(8, 8, 0, 0, 64'h38, 0, 100);
        for (int i = 0; i < 8 && i < wlog.size(); i++) chk("stall_order", wlog[i], 8 + i);

        // Zero-row fill completes immediately with no writes.
        fill(5, 0, 0, 0, 64'h0, 0, 100);

        // Start pulse mid-fill with a different configuration is ignored.
        i_base = 5'd10; i_nrow = 6'd6; i_xor_mask = 4'd0; i_xor_scheme = 8'd0;
        wlog.delete();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        i_base = 5'd3; i_nrow = 6'd2; i_xor_mask = 4'hf; i_xor_scheme = 8'hff;
        step(1'b1, 1'b0, 1'b1);
        run(64'h0, 0, 100);
        exp_m = '{10, 11, 12, 13, 14, 15};
        chk("ign_nwrites", wlog.size(), 6);
        for (int i = 0; i < 6 && i < wlog.size(); i++) chk("ign_addr", wlog[i], exp_m[i]);

        // Reset after two of five rows retire.
        i_base = 5'd5; i_nrow = 6'd5; i_xor_mask = 4'd3; i_xor_scheme = 8'h21;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        i_rst = 1'b0;
        #1;
        check_reset_outputs();
        m_mode = 0; q_addr.delete(); q_data.delete();
        i_dval = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        fill(0, 4, 0, 0, 64'h0, 0, 100);
        exp_w = '{0, 1, 2, 3};
        for (int i = 0; i < 4 && i < wlog.size(); i++) chk("post_rst_addr", wlog[i], exp_w[i]);

        // Randomized fills with stalls, gaps and arbitrary butterfly schedules.
        for (int n = 0; n < 8; n++) begin
            fill($urandom_range(0, NDATA - 1), $urandom_range(1, NDATA), $urandom_range(0, 15),
                 $urandom_range(0, 255), 64'h0, 25, 75);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
